// File: rtl/kernel_serializer_pkg.sv
// -----------------------------------------------------------------------------
// kernel_serializer_pkg
// Shared parameters for the 3x3 kernel datapath (serializer and collector).
//   DATA_WIDTH_DEF : default width of one kernel/window word
//   NUM_WORDS_DEF  : default words per frame (3x3 kernel)
//   IDX_W          : width of the word index carried alongside serial data
//   ser_state_e    : serializer FSM state encoding
// -----------------------------------------------------------------------------
package kernel_serializer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_WORDS_DEF  = 9;
  localparam int IDX_W          = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no frame held
    ST_SEND = 1'b1   // emitting words of the held frame
  } ser_state_e;

endpackage

// File: rtl/kernel_serializer.sv
// -----------------------------------------------------------------------------
// kernel_serializer
// Parallel-to-serial counterpart of the 9-word kernel collector. A whole frame
// is latched on accept and emitted one word per transfer, word 0 first, so that
// serializer -> collector reproduces kernel_in bit-exact.
//
// Handshakes (valid/ready, both sides):
//   upstream   : a frame moves when valid_in & ready_out at a rising edge;
//                upstream holds valid_in/kernel_in until that happens.
//   downstream : a word moves when valid_out & beat_en at a rising edge;
//                data_out/index_out/last_out stay put until it does.
//                beat_en is ready_in when SER_STALL_EN is defined, else 1.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-low reset
//   valid_in   kernel_in holds a frame
//   kernel_in  frame, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ready_in   downstream accepts word (only with SER_STALL_EN)
//   ready_out  frame accepted this cycle if valid_in
//   data_out   current serial word
//   valid_out  data_out is valid
//   index_out  index of the word on data_out
//   last_out   data_out is word NUM_WORDS-1
//
// Configuration macro: SER_STALL_EN (adds ready_in backpressure).
// -----------------------------------------------------------------------------
module kernel_serializer
  import kernel_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WORDS  = NUM_WORDS_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] kernel_in,
`ifdef SER_STALL_EN
  input  logic                            ready_in,
`endif
  output logic                            ready_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  output logic [IDX_W-1:0]                index_out,
  output logic                            last_out
);

  localparam int FRAME_W = DATA_WIDTH * NUM_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  ser_state_e                state_q, state_d;
  logic [FRAME_W-1:0]        frame_q, frame_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [IDX_W-1:0]          idx_q, idx_d, idx_inc;
  logic                      last_q, last_d;

  logic beat_en;
  logic xfer;
  logic last_xfer;
  logic accept;

`ifdef SER_STALL_EN
  assign beat_en = ready_in;
`else
  assign beat_en = 1'b1;
`endif

  assign xfer      = valid_out & beat_en;
  assign last_xfer = xfer & last_q;
  assign accept    = valid_in & ready_out;
  assign idx_inc   = idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (last_xfer && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. ready_out is gated by rst so no frame is taken during reset.
  // A new frame can be taken on the very cycle the last word leaves, which is
  // what lets back-to-back frames stream without a bubble.
  always_comb begin
    valid_out = (state_q == ST_SEND);
    ready_out = rst & ((state_q == ST_IDLE) | last_xfer);
  end

  // Datapath next values: accept has priority over the end-of-frame clear so
  // a simultaneous accept restarts at word 0 of the new frame.
  always_comb begin
    frame_d = frame_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (accept) begin
      frame_d = kernel_in;
      data_d  = kernel_in[DATA_WIDTH-1:0];
      idx_d   = '0;
      last_d  = (NUM_WORDS == 1);
    end else if (last_xfer) begin
      data_d  = '0;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (xfer) begin
      // idx_inc is at most LAST_IDX here because last_q stops the count.
      data_d  = frame_q[int'(idx_inc)*DATA_WIDTH +: DATA_WIDTH];
      idx_d   = idx_inc;
      last_d  = (idx_inc == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign data_out  = data_q;
  assign index_out = idx_q;
  assign last_out  = last_q;

endmodule
